maxpool_unit: RTL and testbench

Receives requantized, activated int8 values from the requantize controller and performs 2x2, stride-2 max pooling independently on each of `SA_N` channels. Pooled results are emitted with halved coordinates toward the activation write-back path. Values may arrive out of raster order. Per-channel partial-window tables accumulate each window until all four members have arrived. A per-layer bypass passes values straight through for layers without pooling.

---
 rtl/sys_types_pkg.sv | 22 ++
 rtl/maxpool_channel.sv | 113 +++++++++++
 rtl/maxpool_unit.sv | 55 +++++
 tb/tb_maxpool_unit.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sys_types_pkg.sv
// Shared scalar types plus the partial-window entry used by the max-pool tables.
package sys_types;

  typedef logic signed [7:0]  int8_t;
  typedef logic signed [31:0] int32_t;

  // Largest feature-map edge any layer may use; sizes the stored pooled row.
  localparam int POOL_MAX_N  = 64;
  localparam int POOL_P_BITS = $clog2(POOL_MAX_N) - 1;

  typedef struct packed {
    int8_t                  max;
    logic [3:0]             mask;
    logic [POOL_P_BITS-1:0] prow;
  } pool_entry_t;

  // Ties keep the stored value.
  function automatic int8_t smax8(input int8_t stored, input int8_t incoming);
    return (incoming > stored) ? incoming : stored;
  endfunction

endpackage

// File: rtl/maxpool_channel.sv
// One channel of 2x2/stride-2 max pooling: partial-window table keyed by pooled
// column, plus the one-cycle output register shared with the bypass path.
module maxpool_channel
  import sys_types::*;
#(
  parameter int MAX_N  = 64,
  parameter int N_BITS = $clog2(MAX_N),
  parameter int P_BITS = N_BITS - 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              bypass_pool,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [N_BITS-1:0] in_row,
  input  logic [N_BITS-1:0] in_col,
  input  int8_t             in_data,
  output logic              out_valid,
  output logic [N_BITS-1:0] out_row,
  output logic [N_BITS-1:0] out_col,
  output int8_t             out_data,
  output logic              idle,
  output logic              error
);

  localparam int ENTRIES = MAX_N / 2;

  pool_entry_t           r_table [ENTRIES];
  logic                  r_out_valid;
  logic [N_BITS-1:0]     r_out_row;
  logic [N_BITS-1:0]     r_out_col;
  int8_t                 r_out_data;
  logic                  r_error;

  logic [P_BITS-1:0]      w_pc;
  logic [P_BITS-1:0]      w_prow;
  logic [POOL_P_BITS-1:0] w_prow_ext;
  logic [1:0]             w_pos;
  pool_entry_t            w_ent;
  logic                   w_live;
  logic                   w_empty;
  logic                   w_match;
  logic                   w_bit_set;
  logic                   w_accept;
  logic                   w_err;
  logic                   w_done;
  logic                   w_pass;
  logic [3:0]             w_mask_new;
  int8_t                  w_max_new;
  logic                   w_any_mask;

  assign w_pc       = in_col[N_BITS-1:1];
  assign w_prow     = in_row[N_BITS-1:1];
  assign w_prow_ext = POOL_P_BITS'(w_prow);
  assign w_pos      = {in_row[0], in_col[0]};
  assign w_ent      = r_table[w_pc];

  // clear wins over any coincident input, in both modes.
  assign w_live     = in_valid && !clear;
  assign w_pass     = w_live && bypass_pool;
  assign w_empty    = (w_ent.mask == 4'b0000);
  assign w_match    = (w_ent.prow == w_prow_ext);
  assign w_bit_set  = w_ent.mask[w_pos];
  assign w_accept   = w_live && !bypass_pool && (w_empty || (w_match && !w_bit_set));
  assign w_err      = w_live && !bypass_pool && !w_empty && (!w_match || w_bit_set);
  assign w_mask_new = (w_empty ? 4'b0000 : w_ent.mask) | (4'b0001 << w_pos);
  assign w_max_new  = w_empty ? in_data : smax8(w_ent.max, in_data);
  assign w_done     = w_accept && (w_mask_new == 4'b1111);

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < ENTRIES; i++) r_table[i] <= '0;
      r_out_valid <= 1'b0;
      r_out_row   <= '0;
      r_out_col   <= '0;
      r_out_data  <= '0;
      r_error     <= 1'b0;
    end else begin
      r_out_valid <= 1'b0;
      if (w_err) r_error <= 1'b1;
      if (clear) begin
        for (int i = 0; i < ENTRIES; i++) r_table[i].mask <= 4'b0000;
      end else if (w_accept) begin
        // A completed window frees its entry in the same cycle it is emitted.
        r_table[w_pc] <= w_done ? '0 : '{max: w_max_new, mask: w_mask_new, prow: w_prow_ext};
      end
      if (w_done) begin
        r_out_valid <= 1'b1;
        r_out_row   <= N_BITS'(w_prow);
        r_out_col   <= N_BITS'(w_pc);
        r_out_data  <= w_max_new;
      end else if (w_pass) begin
        r_out_valid <= 1'b1;
        r_out_row   <= in_row;
        r_out_col   <= in_col;
        r_out_data  <= in_data;
      end
    end
  end

  always_comb begin
    w_any_mask = 1'b0;
    for (int i = 0; i < ENTRIES; i++) w_any_mask = w_any_mask | (r_table[i].mask != 4'b0000);
  end

  assign out_valid = r_out_valid;
  assign out_row   = r_out_row;
  assign out_col   = r_out_col;
  assign out_data  = r_out_data;
  assign error     = r_error;
  assign idle      = !w_any_mask && !r_out_valid;

endmodule

// File: rtl/maxpool_unit.sv
// SA_N independent max-pool channels between requantize and activation write-back.
module maxpool_unit
  import sys_types::*;
#(
  parameter int SA_N   = 4,
  parameter int MAX_N  = 64,
  parameter int N_BITS = $clog2(MAX_N),
  parameter int P_BITS = N_BITS - 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         bypass_pool,
  input  logic                         clear,
  input  logic [SA_N-1:0]              in_valid,
  input  logic [SA_N-1:0][N_BITS-1:0]  in_row,
  input  logic [SA_N-1:0][N_BITS-1:0]  in_col,
  input  int8_t [SA_N-1:0]             in_data,
  output logic [SA_N-1:0]              out_valid,
  output logic [SA_N-1:0][N_BITS-1:0]  out_row,
  output logic [SA_N-1:0][N_BITS-1:0]  out_col,
  output int8_t [SA_N-1:0]             out_data,
  output logic                         idle,
  output logic                         error
);

  logic [SA_N-1:0] w_err_ch;
  logic [SA_N-1:0] w_idle_ch;

  for (genvar g = 0; g < SA_N; g++) begin : g_ch
    maxpool_channel #(
      .MAX_N (MAX_N),
      .N_BITS(N_BITS),
      .P_BITS(P_BITS)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .bypass_pool(bypass_pool),
      .clear      (clear),
      .in_valid   (in_valid[g]),
      .in_row     (in_row[g]),
      .in_col     (in_col[g]),
      .in_data    (in_data[g]),
      .out_valid  (out_valid[g]),
      .out_row    (out_row[g]),
      .out_col    (out_col[g]),
      .out_data   (out_data[g]),
      .idle       (w_idle_ch[g]),
      .error      (w_err_ch[g])
    );
  end

  assign error = |w_err_ch;
  assign idle  = &w_idle_ch;

endmodule

// File: tb/tb_maxpool_unit.sv
// Bench for maxpool_unit: directed scenarios plus a randomized window stream,
// with a scoreboard of expected outputs keyed by channel.
module tb_maxpool_unit;

  localparam int SA_N   = 4;
  localparam int MAX_N  = 64;
  localparam int N_BITS = 6;
  localparam int W      = 2 + 2 * N_BITS + 8;

  logic                        clk;
  logic                        reset;
  logic                        bypass_pool;
  logic                        clear;
  logic [SA_N-1:0]             in_valid;
  logic [SA_N-1:0][N_BITS-1:0] in_row;
  logic [SA_N-1:0][N_BITS-1:0] in_col;
  logic [SA_N-1:0][7:0]        in_data;
  logic [SA_N-1:0]             out_valid;
  logic [SA_N-1:0][N_BITS-1:0] out_row;
  logic [SA_N-1:0][N_BITS-1:0] out_col;
  logic [SA_N-1:0][7:0]        out_data;
  logic                        idle;
  logic                        error;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;
  int n_out  = 0;

  maxpool_unit #(.SA_N(SA_N), .MAX_N(MAX_N), .N_BITS(N_BITS), .P_BITS(N_BITS - 1)) dut (
    .clk(clk), .reset(reset), .bypass_pool(bypass_pool), .clear(clear),
    .in_valid(in_valid), .in_row(in_row), .in_col(in_col), .in_data(in_data),
    .out_valid(out_valid), .out_row(out_row), .out_col(out_col), .out_data(out_data),
    .idle(idle), .error(error)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard: each output pulse must match the oldest pending entry for its channel
  always @(negedge clk) begin
    for (int c = 0; c < SA_N; c++) begin
      if (out_valid[c] === 1'b1) begin
        int found;
        logic [1:0]   cc;
        logic [W-1:0] got;
        found = -1;
        cc = c[1:0];
        for (int i = 0; i < exp_q.size(); i++)
          if (found < 0 && exp_q[i][W-1:W-2] == cc) found = i;
        checks++;
        got = {cc, out_row[c], out_col[c], out_data[c]};
        if (found < 0) begin
          errors++;
          $display("FAIL unexpected_out ch=%0d got row=%0d col=%0d data=%0d, required no output",
                   c, out_row[c], out_col[c], $signed(out_data[c]));
        end else begin
          if (got !== exp_q[found]) begin
            errors++;
            $display("FAIL out_match ch=%0d got row=%0d col=%0d data=%0d, required row=%0d col=%0d data=%0d",
                     c, out_row[c], out_col[c], $signed(out_data[c]),
                     exp_q[found][W-3 -: N_BITS], exp_q[found][7+N_BITS -: N_BITS],
                     $signed(exp_q[found][7:0]));
          end
          exp_q.delete(found);
        end
        n_out++;
      end
    end
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
    in_valid = '0;
    clear    = 1'b0;
  endtask

  task automatic set_in(input int ch, input int row, input int col, input int data);
    logic [31:0] r, c, d;
    r = row; c = col; d = data;
    in_valid[ch] = 1'b1;
    in_row[ch]   = r[N_BITS-1:0];
    in_col[ch]   = c[N_BITS-1:0];
    in_data[ch]  = d[7:0];
  endtask

  task automatic push_exp(input int ch, input int row, input int col, input int data);
    logic [31:0] ch_v, r, c, d;
    ch_v = ch; r = row; c = col; d = data;
    exp_q.push_back({ch_v[1:0], r[N_BITS-1:0], c[N_BITS-1:0], d[7:0]});
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic check_bit(input string name, input logic got, input logic req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0b required=%0b", name, got, req);
    end
  endtask

  task automatic check_int(input string name, input int got, input int req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got=%0d required=%0d", name, got, req);
    end
  endtask

  // scenarios
  task automatic test_reset();
    checks++;
    if (out_valid !== '0 || out_row !== '0 || out_col !== '0 || out_data !== '0) begin
      errors++;
      $display("FAIL reset_outputs got valid=%b row=%h col=%h data=%h, required all zero",
               out_valid, out_row, out_col, out_data);
    end
    check_bit("reset_idle", idle, 1'b1);
    check_bit("reset_error", error, 1'b0);
  endtask

  task automatic test_basic();
    int base;
    base = n_out;
    set_in(0, 0, 0, 5);    step();
    set_in(0, 0, 1, -3);   step();
    set_in(0, 1, 0, 17);   step();
    check_int("basic_no_early_out", n_out - base, 0);
    push_exp(0, 0, 0, 17);
    set_in(0, 1, 1, 2);    step();
    check_bit("basic_valid_at_latency", out_valid[0], 1'b1);
    step();
    check_int("basic_out_count", n_out - base, 1);
    check_bit("basic_idle_after", idle, 1'b1);
  endtask

  task automatic test_negatives();
    int base;
    base = n_out;
    set_in(0, 3, 5, -100); step();
    set_in(0, 2, 4, -128); step();
    set_in(0, 3, 4, -90);  step();
    push_exp(0, 1, 2, -90);
    set_in(0, 2, 5, -127); step();
    step();
    check_int("neg_out_count", n_out - base, 1);
    check_bit("neg_idle_after", idle, 1'b1);
  endtask

  task automatic test_interleaved();
    int mx[SA_N][2];
    int order[4];
    int base;
    order = '{3, 0, 2, 1};
    base = n_out;
    for (int k = 0; k < 4; k++) begin
      for (int w = 0; w < 2; w++) begin
        for (int c = 0; c < SA_N; c++) begin
          int d, pos, pc;
          d = int'($urandom_range(0, 255)) - 128;
          pos = order[k];
          pc = 3 + w;
          if (k == 0 || d > mx[c][w]) mx[c][w] = d;
          set_in(c, 10 + pos / 2, 2 * pc + pos % 2, d);
          if (k == 3) push_exp(c, 5, pc, mx[c][w]);
        end
        step();
      end
      if (k == 1) check_bit("inter_not_idle", idle, 1'b0);
    end
    step();
    check_int("inter_out_count", n_out - base, 2 * SA_N);
    check_bit("inter_idle_after", idle, 1'b1);
  endtask

  task automatic test_duplicate();
    int base;
    base = n_out;
    set_in(1, 0, 0, 10); step();
    set_in(1, 0, 0, 50); step();
    check_bit("dup_error", error, 1'b1);
    check_bit("dup_not_idle", idle, 1'b0);
    check_int("dup_no_out", n_out - base, 0);
    // the dropped 50 must not have reached the stored max
    set_in(1, 0, 1, 3);  step();
    set_in(1, 1, 0, -5); step();
    push_exp(1, 0, 0, 10);
    set_in(1, 1, 1, 7);  step();
    step();
    check_int("dup_single_bit_out", n_out - base, 1);
    set_in(1, 0, 0, 1);  step();
    check_bit("dup_partial_not_idle", idle, 1'b0);
    clear = 1'b1;        step();
    check_bit("dup_clear_idle", idle, 1'b1);
    check_bit("dup_error_sticky", error, 1'b1);
    do_reset();
    check_bit("dup_reset_error", error, 1'b0);
    // prow mismatch on an open entry is also a violation
    set_in(2, 0, 0, 1);  step();
    set_in(2, 2, 1, 2);  step();
    check_bit("prow_mismatch_error", error, 1'b1);
    do_reset();
    check_bit("prow_reset_idle", idle, 1'b1);
  endtask

  task automatic test_bypass();
    int base;
    base = n_out;
    bypass_pool = 1'b1;
    push_exp(3, 7, 9, 42);
    set_in(3, 7, 9, 42); step();
    check_bit("bypass_valid", out_valid[3], 1'b1);
    push_exp(0, 63, 62, -1);
    push_exp(2, 0, 1, -128);
    set_in(0, 63, 62, -1);
    set_in(2, 0, 1, -128); step();
    step();
    check_int("bypass_out_count", n_out - base, 3);
    check_bit("bypass_tables_empty", idle, 1'b1);
    bypass_pool = 1'b0;
  endtask

  task automatic test_clear_collision();
    int base;
    base = n_out;
    set_in(0, 4, 6, 11); step();
    set_in(0, 4, 7, 12); step();
    set_in(0, 5, 6, 13); step();
    set_in(0, 5, 7, 99);
    clear = 1'b1;        step();
    step();
    check_int("clear_coll_no_out", n_out - base, 0);
    check_bit("clear_coll_idle", idle, 1'b1);
    check_bit("clear_coll_error", error, 1'b0);
  endtask

  task automatic test_back_to_back();
    int base;
    base = n_out;
    for (int n = 0; n < 16; n++) begin
      int pc[SA_N], pr[SA_N], mx[SA_N];
      int perm[SA_N][4];
      for (int c = 0; c < SA_N; c++) begin
        pc[c] = int'($urandom_range(0, 31));
        pr[c] = int'($urandom_range(0, 31));
        for (int p = 0; p < 4; p++) perm[c][p] = p;
        for (int p = 3; p > 0; p--) begin
          int j, t;
          j = int'($urandom_range(0, p));
          t = perm[c][p]; perm[c][p] = perm[c][j]; perm[c][j] = t;
        end
      end
      for (int k = 0; k < 4; k++) begin
        for (int c = 0; c < SA_N; c++) begin
          int d, pos;
          d = int'($urandom_range(0, 255)) - 128;
          pos = perm[c][k];
          if (k == 0 || d > mx[c]) mx[c] = d;
          set_in(c, 2 * pr[c] + pos / 2, 2 * pc[c] + pos % 2, d);
          if (k == 3) push_exp(c, pr[c], pc[c], mx[c]);
        end
        step();
      end
    end
    step();
    check_int("b2b_out_count", n_out - base, 16 * SA_N);
    check_bit("b2b_error", error, 1'b0);
    check_bit("b2b_idle", idle, 1'b1);
  endtask

  initial begin
    reset = 1'b1;
    bypass_pool = 1'b0;
    clear = 1'b0;
    in_valid = '0;
    in_row = '0;
    in_col = '0;
    in_data = '0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    test_reset();
    test_basic();
    test_negatives();
    test_interleaved();
    test_duplicate();
    test_bypass();
    test_clear_collision();
    test_back_to_back();

    check_int("pending_expected", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
